// File: rtl/rc4_pkg.sv
// Shared types for the RC4 stream core: FSM state encoding, S-box size and byte type.
package rc4_pkg;
    localparam int SBOX_SIZE = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        KEY_LOAD,
        SINIT,
        KSA,
        DROP,
        STREAM
    } state_t;
endpackage

// File: rtl/rc4_sbox.sv
// 256x8 RC4 state array: three combinational reads, a swap write on (ra, rb) and an init write.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] ra,
    input  logic [7:0] rb,
    input  logic [7:0] rt,
    output logic [7:0] da,
    output logic [7:0] db,
    output logic [7:0] dt,
    input  logic       swap_en,
    input  logic       init_en,
    input  logic [7:0] init_addr,
    input  logic [7:0] init_data
);
    byte_t s [SBOX_SIZE];

    assign da = s[ra];
    assign db = s[rb];
    assign dt = s[rt];

    always_ff @(posedge clk) begin
        if (init_en) begin
            s[init_addr] <= init_data;
        end else if (swap_en) begin
            s[ra] <= db;
            // When ra == rb the entry keeps its value; a single write avoids two drivers.
            if (ra != rb)
                s[rb] <= da;
        end
    end
endmodule

// File: rtl/rc4_stream_core.sv
// RC4 stream engine: key load, S-box init, KSA, optional dropN discard, then XOR of the byte stream.
module rc4_stream_core
    import rc4_pkg::*;
#(
    parameter int KEY_LEN_MAX = 16,
    parameter int DROP_N      = 0,
    parameter int DROP_W      = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [7:0] key_data,
    input  logic       key_last,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [7:0] din_data,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [7:0] dout_data,
    output logic       key_err,
    output logic       busy
);
    localparam int LW = $clog2(KEY_LEN_MAX + 1);
    localparam int KW = (KEY_LEN_MAX > 1) ? $clog2(KEY_LEN_MAX) : 1;

    state_t            state;
    logic [7:0]        i, j;
    logic [LW-1:0]     klen;
    logic [KW-1:0]     kidx;
    logic [DROP_W-1:0] drop_cnt;
    logic [7:0]        key_mem [KEY_LEN_MAX];

    logic [7:0] ra, rt, da, db, dt, j_next, kbyte, ks;
    logic       key_fire, din_fire, step;

    assign key_ready = (state == IDLE) || (state == KEY_LOAD) || (state == STREAM && !dout_valid);
    assign key_fire  = key_valid && key_ready;
    // A key byte wins over data in the same cycle so a rekey never races a keystream step.
    assign din_ready = (state == STREAM) && (!dout_valid || dout_ready) && !key_fire;
    assign din_fire  = din_valid && din_ready;
    assign busy      = state inside {KEY_LOAD, SINIT, KSA, DROP};
    assign step      = (state == DROP) || din_fire;

    // KSA reads S[i]; PRGA reads S[i+1]. Post-swap S[t] is forwarded from the pre-swap reads.
    assign kbyte  = key_mem[kidx];
    assign ra     = (state == KSA) ? i : i + 8'd1;
    assign j_next = j + da + ((state == KSA) ? kbyte : 8'd0);
    assign rt     = da + db;
    assign ks     = (rt == ra) ? db : (rt == j_next) ? da : dt;

    rc4_sbox u_sbox (
        .clk       (clk),
        .ra        (ra),
        .rb        (j_next),
        .rt        (rt),
        .da        (da),
        .db        (db),
        .dt        (dt),
        .swap_en   ((state == KSA) || step),
        .init_en   (state == SINIT),
        .init_addr (i),
        .init_data (i)
    );

    always_ff @(posedge clk) begin
        if (key_fire) begin
            if (state == KEY_LOAD) begin
                if (klen < LW'(KEY_LEN_MAX))
                    key_mem[klen[KW-1:0]] <= key_data;
            end else begin
                key_mem[0] <= key_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            klen       <= '0;
            kidx       <= '0;
            drop_cnt   <= '0;
            key_err    <= 1'b0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
        end else begin
            if (din_fire) begin
                dout_data  <= din_data ^ ks;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end

            case (state)
                IDLE, STREAM: begin
                    if (key_fire) begin
                        klen    <= LW'(1);
                        key_err <= 1'b0;
                        i       <= '0;
                        state   <= key_last ? SINIT : KEY_LOAD;
                    end else if (din_fire) begin
                        i <= ra;
                        j <= j_next;
                    end
                end
                KEY_LOAD: begin
                    if (key_fire) begin
                        if (klen < LW'(KEY_LEN_MAX))
                            klen <= klen + LW'(1);
                        else
                            key_err <= 1'b1;
                        if (key_last)
                            state <= SINIT;
                    end
                end
                SINIT: begin
                    i <= i + 8'd1;
                    if (i == 8'hFF) begin
                        j     <= '0;
                        kidx  <= '0;
                        state <= KSA;
                    end
                end
                KSA: begin
                    i    <= i + 8'd1;
                    j    <= j_next;
                    kidx <= (LW'(kidx) + LW'(1) == klen) ? '0 : kidx + KW'(1);
                    if (i == 8'hFF) begin
                        j        <= '0;
                        drop_cnt <= '0;
                        state    <= (DROP_N == 0) ? STREAM : DROP;
                    end
                end
                DROP: begin
                    i        <= ra;
                    j        <= j_next;
                    drop_cnt <= drop_cnt + DROP_W'(1);
                    if (drop_cnt == DROP_W'(DROP_N - 1))
                        state <= STREAM;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc4_stream_core.sv
// Bench for rc4_stream_core: three instances (default, drop-3, 2-byte key) against a plain RC4 model.
module tb_rc4_stream_core;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [3], key_valid [3], key_ready [3], key_last [3];
    logic       din_valid [3], din_ready [3], dout_valid [3], dout_ready [3];
    logic       key_err [3], busy [3];
    logic [7:0] key_data [3], din_data [3], dout_data [3];

    int  checks = 0, failures = 0, cur = 0;
    bq_t expq, got;
    int  ms [3][256];
    int  mi [3], mj [3];

    rc4_stream_core u0 (
        .clk(clk), .rst(rst[0]), .key_valid(key_valid[0]), .key_ready(key_ready[0]),
        .key_data(key_data[0]), .key_last(key_last[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .din_data(din_data[0]), .dout_valid(dout_valid[0]),
        .dout_ready(dout_ready[0]), .dout_data(dout_data[0]), .key_err(key_err[0]), .busy(busy[0]));

    rc4_stream_core #(.DROP_N(3)) u1 (
        .clk(clk), .rst(rst[1]), .key_valid(key_valid[1]), .key_ready(key_ready[1]),
        .key_data(key_data[1]), .key_last(key_last[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .din_data(din_data[1]), .dout_valid(dout_valid[1]),
        .dout_ready(dout_ready[1]), .dout_data(dout_data[1]), .key_err(key_err[1]), .busy(busy[1]));

    rc4_stream_core #(.KEY_LEN_MAX(2)) u2 (
        .clk(clk), .rst(rst[2]), .key_valid(key_valid[2]), .key_ready(key_ready[2]),
        .key_data(key_data[2]), .key_last(key_last[2]), .din_valid(din_valid[2]),
        .din_ready(din_ready[2]), .din_data(din_data[2]), .dout_valid(dout_valid[2]),
        .dout_ready(dout_ready[2]), .dout_data(dout_data[2]), .key_err(key_err[2]), .busy(busy[2]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Textbook RC4: KSA over the effective key, then PRGA one byte per call.
    function automatic int model_next(input int u);
        int t;
        mi[u] = (mi[u] + 1) % 256;
        mj[u] = (mj[u] + ms[u][mi[u]]) % 256;
        t = ms[u][mi[u]]; ms[u][mi[u]] = ms[u][mj[u]]; ms[u][mj[u]] = t;
        return ms[u][(ms[u][mi[u]] + ms[u][mj[u]]) % 256];
    endfunction

    task automatic model_key(input int u, input bq_t k, input int n, input int drop);
        int t;
        for (int c = 0; c < 256; c++) ms[u][c] = c;
        mj[u] = 0;
        for (int c = 0; c < 256; c++) begin
            mj[u] = (mj[u] + ms[u][c] + int'(k[c % n])) % 256;
            t = ms[u][c]; ms[u][c] = ms[u][mj[u]]; ms[u][mj[u]] = t;
        end
        mi[u] = 0; mj[u] = 0;
        repeat (drop) void'(model_next(u));
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int n = 0; n < s.len(); n++) q.push_back(s[n]);
        return q;
    endfunction

    function automatic bq_t zeros(input int n);
        bq_t q;
        for (int c = 0; c < n; c++) q.push_back(8'h00);
        return q;
    endfunction

    // Single compare process: every accepted output byte is checked against the model stream.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++)
            if (dout_valid[u] && !dout_ready[u] && !rst[u])
                chk("din_ready under backpressure", int'(din_ready[u]), 0);
        if (rst[cur]) begin
            expq.delete();
        end else begin
            if (dout_valid[cur] && dout_ready[cur]) begin
                got.push_back(dout_data[cur]);
                if (expq.size() == 0) chk("unexpected dout", 1, 0);
                else chk("dout vs model", int'(dout_data[cur]), int'(expq.pop_front()));
            end
            if (din_valid[cur] && din_ready[cur])
                expq.push_back(din_data[cur] ^ 8'(model_next(cur)));
        end
    end

    task automatic send_key(input int u, input bq_t k);
        int t;
        for (int n = 0; n < k.size(); n++) begin
            t = 0;
            key_valid[u] = 1'b1; key_data[u] = k[n]; key_last[u] = (n == k.size() - 1);
            @(negedge clk);
            while (!key_ready[u] && t < 2000) begin @(negedge clk); t++; end
            if (t >= 2000) chk("key accept timeout", 0, 1);
            @(posedge clk); #1;
        end
        key_valid[u] = 1'b0; key_last[u] = 1'b0;
    endtask

    task automatic wait_busy(input int u, input int exp, input string name);
        int n;
        n = 0;
        while (busy[u] && n < 3000) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                chk("key_ready during setup", int'(key_ready[u]), 0);
                chk("din_ready during setup", int'(din_ready[u]), 0);
            end
        end
        chk(name, n, exp);
    endtask

    task automatic send_din(input int u, input bq_t d, input bit bp);
        int idx, t;
        idx = 0; t = 0;
        while (idx < d.size() && t < 3000) begin
            dout_ready[u] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            din_valid[u] = 1'b1; din_data[u] = d[idx];
            @(negedge clk);
            if (din_ready[u]) idx++;
            @(posedge clk); #1; t++;
        end
        if (t >= 3000) chk("din accept timeout", 0, 1);
        din_valid[u] = 1'b0; dout_ready[u] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input bq_t e);
        chk({name, " count"}, got.size(), e.size());
        for (int n = 0; n < e.size() && n < got.size(); n++) chk(name, int'(got[n]), int'(e[n]));
        got.delete();
    endtask

    initial begin
        bq_t e;
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; key_valid[u] = 1'b0; key_last[u] = 1'b0; key_data[u] = '0;
            din_valid[u] = 1'b0; din_data[u] = '0; dout_ready[u] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        for (int u = 0; u < 3; u++) begin
            chk("reset key_ready", int'(key_ready[u]), 1);
            chk("reset din_ready", int'(din_ready[u]), 0);
            chk("reset dout_valid", int'(dout_valid[u]), 0);
            chk("reset dout_data", int'(dout_data[u]), 0);
            chk("reset key_err", int'(key_err[u]), 0);
            chk("reset busy", int'(busy[u]), 0);
        end

        cur = 0;
        model_key(0, s2q("Key"), 3, 0);
        send_key(0, s2q("Key"));
        wait_busy(0, 512, "setup cycles Key");
        send_din(0, s2q("Plaintext"), 1'b0);
        e = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        check_out("Key/Plaintext", e);

        model_key(0, s2q("Wiki"), 4, 0);
        send_key(0, s2q("Wiki"));
        wait_busy(0, 512, "setup cycles Wiki");
        send_din(0, s2q("pedia"), 1'b0);
        e = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
        check_out("Wiki/pedia", e);

        model_key(0, s2q("Secret"), 6, 0);
        send_key(0, s2q("Secret"));
        wait_busy(0, 512, "setup cycles Secret");
        send_din(0, s2q("Attack at dawn"), 1'b0);
        e = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38,
              8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
        check_out("Secret/Attack at dawn", e);

        model_key(0, s2q("Key"), 3, 0);
        send_key(0, s2q("Key"));
        wait_busy(0, 512, "setup cycles rekey");
        send_din(0, zeros(10), 1'b1);
        e = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        check_out("backpressure keystream", e);
        chk("key_err after valid rekey", int'(key_err[0]), 0);

        cur = 1;
        model_key(1, s2q("Key"), 3, 3);
        send_key(1, s2q("Key"));
        wait_busy(1, 515, "setup cycles drop3");
        send_din(1, zeros(7), 1'b0);
        e = '{8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        check_out("drop3 keystream", e);

        cur = 2;
        model_key(2, s2q("Key"), 2, 0);
        send_key(2, s2q("Key"));
        chk("key_err on truncation", int'(key_err[2]), 1);
        wait_busy(2, 512, "setup cycles truncated");
        send_din(2, zeros(8), 1'b0);
        chk("truncated key output count", got.size(), 8);
        got.delete();

        send_key(2, s2q("Key"));
        repeat (400) @(posedge clk);
        #1;
        chk("busy during KSA", int'(busy[2]), 1);
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        chk("rst mid-KSA key_ready", int'(key_ready[2]), 1);
        chk("rst mid-KSA dout_valid", int'(dout_valid[2]), 0);
        chk("rst mid-KSA key_err", int'(key_err[2]), 0);
        chk("rst mid-KSA busy", int'(busy[2]), 0);
        chk("rst mid-KSA din_ready", int'(din_ready[2]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
